// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency memory port between the CPU datapath and a debug/loader port.
// Optional statistics counters are enabled by defining MEM_ARB_STATS_EN.
`timescale 1ns/1ps
module mem_port_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int LATENCY = 1
`ifdef MEM_ARB_STATS_EN
  , parameter int CNTW  = 16
`endif
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_rd,
  input  logic          cpu_wr,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_stall,
  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic [AW-1:0] dbg_addr,
  input  logic [DW-1:0] dbg_wdata,
  output logic [DW-1:0] dbg_rdata,
  output logic          dbg_ack,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
`ifdef MEM_ARB_STATS_EN
  , output logic [CNTW-1:0] stat_cpu
  , output logic [CNTW-1:0] stat_dbg
  , output logic [CNTW-1:0] stat_stall
`endif
);

  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  typedef enum logic {OWN_CPU, OWN_DBG} owner_t;

  state_t        state, state_nxt;
  owner_t        owner, last_owner, grant;
  logic          cpu_req, grant_en, we_r, cnt_zero;
  logic [CW-1:0] cnt;

  assign cpu_req  = cpu_rd | cpu_wr;
  assign cnt_zero = (cnt == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Grants happen only from IDLE, so a request still high during DONE is not re-served.
  always_comb begin
    state_nxt = state;
    grant_en  = 1'b0;
    grant     = OWN_CPU;
    case (state)
      IDLE: begin
        if (cpu_req || dbg_req) begin
          grant_en  = 1'b1;
          state_nxt = ACCESS;
          if (cpu_req && dbg_req) grant = (last_owner == OWN_DBG) ? OWN_CPU : OWN_DBG;
          else                    grant = cpu_req ? OWN_CPU : OWN_DBG;
        end
      end
      ACCESS:  if (cnt_zero) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign mem_en    = (state == ACCESS);
  assign mem_we    = mem_en & we_r;
  assign dbg_ack   = (state == DONE) && (owner == OWN_DBG);
  assign cpu_stall = cpu_req & ~((state == DONE) && (owner == OWN_CPU));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner      <= OWN_CPU;
      last_owner <= OWN_DBG;
      we_r       <= 1'b0;
      cnt        <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      cpu_rdata  <= '0;
      dbg_rdata  <= '0;
    end else begin
      if (grant_en) begin
        owner      <= grant;
        last_owner <= grant;
        cnt        <= CW'(LATENCY - 1);
        if (grant == OWN_CPU) begin
          mem_addr  <= cpu_addr;
          mem_wdata <= cpu_wdata;
          we_r      <= cpu_wr;
        end else begin
          mem_addr  <= dbg_addr;
          mem_wdata <= dbg_wdata;
          we_r      <= dbg_we;
        end
      end
      if (state == ACCESS) begin
        if (cnt_zero) begin
          if (!we_r) begin
            if (owner == OWN_CPU) cpu_rdata <= mem_rdata;
            else                  dbg_rdata <= mem_rdata;
          end
        end else begin
          cnt <= cnt - 1'b1;
        end
      end
    end
  end

`ifdef MEM_ARB_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_cpu   <= '0;
      stat_dbg   <= '0;
      stat_stall <= '0;
    end else begin
      if (state == DONE && owner == OWN_CPU && stat_cpu != '1) stat_cpu <= stat_cpu + 1'b1;
      if (dbg_ack && stat_dbg != '1)                            stat_dbg <= stat_dbg + 1'b1;
      if (cpu_stall && stat_stall != '1)                        stat_stall <= stat_stall + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: instance 0 at LATENCY=1, instance 1 at LATENCY=3.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

  localparam int LAT0 = 1;
  localparam int LAT1 = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_rd[2], cpu_wr[2], dbg_req[2], dbg_we[2];
  logic [31:0] cpu_addr[2], cpu_wdata[2], dbg_addr[2], dbg_wdata[2], mem_rdata[2];
  logic [31:0] cpu_rdata[2], dbg_rdata[2], mem_addr[2], mem_wdata[2];
  logic        cpu_stall[2], dbg_ack[2], mem_en[2], mem_we[2];
`ifdef MEM_ARB_STATS_EN
  logic [15:0] s0_cpu, s0_dbg, s0_stall;
  logic [1:0]  s1_cpu, s1_dbg, s1_stall;
`endif

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  mem_port_arbiter #(.AW(32), .DW(32), .LATENCY(LAT0)
`ifdef MEM_ARB_STATS_EN
    , .CNTW(16)
`endif
  ) u_dut0 (
    .clk(clk), .reset(reset),
    .cpu_rd(cpu_rd[0]), .cpu_wr(cpu_wr[0]), .cpu_addr(cpu_addr[0]), .cpu_wdata(cpu_wdata[0]),
    .cpu_rdata(cpu_rdata[0]), .cpu_stall(cpu_stall[0]),
    .dbg_req(dbg_req[0]), .dbg_we(dbg_we[0]), .dbg_addr(dbg_addr[0]), .dbg_wdata(dbg_wdata[0]),
    .dbg_rdata(dbg_rdata[0]), .dbg_ack(dbg_ack[0]),
    .mem_en(mem_en[0]), .mem_we(mem_we[0]), .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]),
    .mem_rdata(mem_rdata[0])
`ifdef MEM_ARB_STATS_EN
    , .stat_cpu(s0_cpu), .stat_dbg(s0_dbg), .stat_stall(s0_stall)
`endif
  );

  mem_port_arbiter #(.AW(32), .DW(32), .LATENCY(LAT1)
`ifdef MEM_ARB_STATS_EN
    , .CNTW(2)
`endif
  ) u_dut1 (
    .clk(clk), .reset(reset),
    .cpu_rd(cpu_rd[1]), .cpu_wr(cpu_wr[1]), .cpu_addr(cpu_addr[1]), .cpu_wdata(cpu_wdata[1]),
    .cpu_rdata(cpu_rdata[1]), .cpu_stall(cpu_stall[1]),
    .dbg_req(dbg_req[1]), .dbg_we(dbg_we[1]), .dbg_addr(dbg_addr[1]), .dbg_wdata(dbg_wdata[1]),
    .dbg_rdata(dbg_rdata[1]), .dbg_ack(dbg_ack[1]),
    .mem_en(mem_en[1]), .mem_we(mem_we[1]), .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]),
    .mem_rdata(mem_rdata[1])
`ifdef MEM_ARB_STATS_EN
    , .stat_cpu(s1_cpu), .stat_dbg(s1_dbg), .stat_stall(s1_stall)
`endif
  );

  // Memory model: read data is only valid in the last ACCESS cycle.
  logic [31:0] mem [2][256];
  int          en_cnt[2];
  logic        loaded = 1'b0;

  always @(posedge clk) begin
    if (!loaded) begin
      mem[0][8'h10] <= 32'hDEAD_BEEF;
      mem[1][8'h40] <= 32'h5A5A_0001;
      mem[1][8'h44] <= 32'h1357_9BDF;
      loaded        <= 1'b1;
    end
    for (int i = 0; i < 2; i++) begin
      if (mem_en[i]) begin
        if (mem_we[i]) mem[i][mem_addr[i][7:0]] <= mem_wdata[i];
        en_cnt[i] <= en_cnt[i] + 1;
      end else begin
        en_cnt[i] <= 0;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      mem_rdata[i] = 32'hBAD0_BAD0;
      if (mem_en[i] && en_cnt[i] == ((i == 0) ? LAT0 : LAT1) - 1)
        mem_rdata[i] = mem[i][mem_addr[i][7:0]];
    end
  end

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  typedef struct {
    int          inst;
    int          cyc;
    logic [31:0] data;
    bit          chk_data;
  } exp_t;

  exp_t cq[$];
  exp_t dq[$];

  task automatic check_done(input bit is_dbg, input int i, input logic [31:0] rd);
    exp_t  e;
    string tag;
    tag = is_dbg ? "dbg" : "cpu";
    if ((is_dbg && dq.size() == 0) || (!is_dbg && cq.size() == 0)) begin
      n_chk++;
      $display("FAIL %s_unexpected: inst %0d completed at cycle %0d, none expected", tag, i, cyc);
      return;
    end
    if (is_dbg) e = dq.pop_front();
    else        e = cq.pop_front();
    chk($sformatf("%s_inst", tag), i, e.inst);
    chk($sformatf("%s_done_cycle inst%0d", tag, i), cyc, e.cyc);
    if (e.chk_data) chk($sformatf("%s_rdata inst%0d", tag, i), rd, e.data);
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (reset && (cpu_rd[i] || cpu_wr[i]) && !cpu_stall[i]) check_done(1'b0, i, cpu_rdata[i]);
      if (dbg_ack[i]) check_done(1'b1, i, dbg_rdata[i]);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_op(input int i, input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_data, input int off);
    exp_t e;
    bit   done;
    e.inst = i; e.cyc = cyc + off; e.data = exp_data; e.chk_data = !we;
    cq.push_back(e);
    cpu_rd[i] = !we; cpu_wr[i] = we; cpu_addr[i] = addr; cpu_wdata[i] = wdata;
    done = 1'b0;
    for (int n = 0; n < 40 && !done; n++) begin
      @(negedge clk);
      if (!cpu_stall[i]) done = 1'b1;
    end
    if (!done) begin
      n_chk++;
      $display("FAIL cpu_timeout inst%0d: stall still %b after 40 cycles, required 0", i, cpu_stall[i]);
    end
    tick();
    cpu_rd[i] = 1'b0; cpu_wr[i] = 1'b0;
  endtask

  task automatic dbg_op(input int i, input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_data, input int off);
    exp_t e;
    bit   done;
    e.inst = i; e.cyc = cyc + off; e.data = exp_data; e.chk_data = !we;
    dq.push_back(e);
    dbg_req[i] = 1'b1; dbg_we[i] = we; dbg_addr[i] = addr; dbg_wdata[i] = wdata;
    done = 1'b0;
    for (int n = 0; n < 40 && !done; n++) begin
      @(negedge clk);
      if (dbg_ack[i]) done = 1'b1;
    end
    if (!done) begin
      n_chk++;
      $display("FAIL dbg_timeout inst%0d: ack still %b after 40 cycles, required 1", i, dbg_ack[i]);
    end
    tick();
    dbg_req[i] = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d required < 10000", cyc);
    $fatal(1);
  end

  initial begin
    int oc0[3] = '{5, 5, 5};
    int od0[3] = '{2, 5, 5};
    int oc1[3] = '{4, 9, 9};
    int od1[3] = '{9, 9, 9};
    for (int i = 0; i < 2; i++) begin
      cpu_rd[i] = 1'b0; cpu_wr[i] = 1'b0; cpu_addr[i] = '0; cpu_wdata[i] = '0;
      dbg_req[i] = 1'b0; dbg_we[i] = 1'b0; dbg_addr[i] = '0; dbg_wdata[i] = '0;
    end
    reset = 1'b0;
    cpu_rd[0] = 1'b1;
    tick();
    tick();
    chk("reset_stall_follows_req", cpu_stall[0], 1);
    chk("reset_mem_en", mem_en[0], 0);
    chk("reset_mem_we", mem_we[0], 0);
    chk("reset_dbg_ack", dbg_ack[0], 0);
    chk("reset_mem_addr", mem_addr[0], 0);
    chk("reset_mem_wdata", mem_wdata[0], 0);
    chk("reset_cpu_rdata", cpu_rdata[0], 0);
    chk("reset_dbg_rdata", dbg_rdata[0], 0);
    cpu_rd[0] = 1'b0;
    reset = 1'b1;
    tick();
    chk("idle_no_req_stall", cpu_stall[0], 0);

    // Tie right after reset: CPU first, debug next.
    fork
      cpu_op(0, 1'b0, 32'h10, '0, 32'hDEAD_BEEF, 2);
      dbg_op(0, 1'b0, 32'h10, '0, 32'hDEAD_BEEF, 5);
    join

    // Single CPU read with port-level timing.
    fork
      cpu_op(0, 1'b0, 32'h10, '0, 32'hDEAD_BEEF, 2);
      begin
        #1;
        chk("rd_c0_mem_en", mem_en[0], 0);
        tick();
        chk("rd_c1_mem_en", mem_en[0], 1);
        chk("rd_c1_mem_we", mem_we[0], 0);
        chk("rd_c1_mem_addr", mem_addr[0], 32'h10);
        tick();
        chk("rd_c2_mem_en", mem_en[0], 0);
      end
    join

    // CPU write; inputs changed mid-access must not reach memory.
    fork
      cpu_op(0, 1'b1, 32'h20, 32'h0000_1234, '0, 2);
      begin
        #1;
        tick();
        chk("wr_c1_mem_en", mem_en[0], 1);
        chk("wr_c1_mem_we", mem_we[0], 1);
        chk("wr_c1_mem_addr", mem_addr[0], 32'h20);
        chk("wr_c1_mem_wdata", mem_wdata[0], 32'h0000_1234);
        cpu_wdata[0] = 32'hFFFF_FFFF;
        cpu_addr[0]  = 32'h30;
      end
    join
    chk("cpu_rdata_held_after_write", cpu_rdata[0], 32'hDEAD_BEEF);
    dbg_op(0, 1'b0, 32'h20, '0, 32'h0000_1234, 2);
    tick();
    chk("dbg_rdata_held", dbg_rdata[0], 32'h0000_1234);
    dbg_op(0, 1'b1, 32'h24, 32'hCAFE_F00D, '0, 2);
    cpu_op(0, 1'b0, 32'h24, '0, 32'hCAFE_F00D, 2);

    // Alternation at LATENCY=1, last owner CPU so debug goes first.
    fork
      for (int k = 0; k < 3; k++) cpu_op(0, 1'b0, 32'h10, '0, 32'hDEAD_BEEF, oc0[k]);
      for (int k = 0; k < 3; k++) dbg_op(0, 1'b0, 32'h20, '0, 32'h0000_1234, od0[k]);
    join

    // Alternation at LATENCY=3, untouched since reset so CPU goes first.
    fork
      for (int k = 0; k < 3; k++) cpu_op(1, 1'b0, 32'h40, '0, 32'h5A5A_0001, oc1[k]);
      for (int k = 0; k < 3; k++) dbg_op(1, 1'b0, 32'h44, '0, 32'h1357_9BDF, od1[k]);
    join

    // Reset in the middle of a LATENCY=3 access; the held request restarts.
    fork
      dbg_op(1, 1'b0, 32'h44, '0, 32'h1357_9BDF, 7);
      begin
        #1;
        tick();
        tick();
        chk("pre_reset_mem_en", mem_en[1], 1);
        reset = 1'b0;
        #1;
        chk("async_reset_mem_en", mem_en[1], 0);
        chk("async_reset_dbg_ack", dbg_ack[1], 0);
        tick();
        reset = 1'b1;
      end
    join

`ifdef MEM_ARB_STATS_EN
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    for (int k = 0; k < 3; k++) cpu_op(0, 1'b0, 32'h10, '0, 32'hDEAD_BEEF, 2);
    chk("stat_cpu", s0_cpu, 3);
    chk("stat_stall", s0_stall, 6);
    chk("stat_dbg", s0_dbg, 0);
    for (int k = 0; k < 4; k++) cpu_op(1, 1'b0, 32'h40, '0, 32'h5A5A_0001, 4);
    chk("stat_cpu_saturated", s1_cpu, 3);
    chk("stat_stall_saturated", s1_stall, 3);
`endif

    tick();
    chk("cpu_queue_drained", cq.size(), 0);
    chk("dbg_queue_drained", dq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
